// File: rtl/noc_port_adapter.sv
// Clocked core port for the asynchronous tree NoC: packs/unpacks 16-bit parity-protected packets
// and bridges valid/ready FIFOs to 4-phase bundled-data channels through req/ack synchronizers.
module noc_port_adapter #(
    parameter logic [3:0]  ADDRESS     = 4'b0000,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [3:0]  tx_dest,
    input  logic [3:0]  tx_data,
    output logic        net_out_req,
    output logic [15:0] net_out_data,
    input  logic        net_out_ack,
    input  logic        net_in_req,
    input  logic [15:0] net_in_data,
    output logic        net_in_ack,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [3:0]  rx_data,
    output logic [3:0]  rx_src,
    output logic        rx_err,
    output logic [15:0] sent_num,
    output logic [15:0] received_num,
    output logic [15:0] err_num
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {StIdle, StSetup, StReqHi, StReqLo} tx_state_e;
    typedef enum logic [0:0] {StRxIdle, StRxAck} rx_state_e;

    // ---------------- synchronizers ----------------
    logic [SYNC_STAGES-1:0] ack_sync_q, req_sync_q;
    logic                   ack_sync, req_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync_q <= '0;
            req_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], net_out_ack};
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], net_in_req};
        end
    end

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];
    assign req_sync = req_sync_q[SYNC_STAGES-1];

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [AW:0]   tx_count_q;
    logic          tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]    tx_head;
    logic [12:0]   tx_body;

    assign tx_full  = (tx_count_q == CNT_FULL);
    assign tx_empty = (tx_count_q == '0);
    assign tx_ready = !tx_full || tx_pop;
    // Self-addressed requests are handshaken but never stored.
    assign tx_push  = tx_valid && tx_ready && (tx_dest != ADDRESS);
    assign tx_head  = tx_mem[tx_rd_ptr_q];
    assign tx_body  = {1'b0, ADDRESS, tx_head};

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= {tx_dest, tx_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PTR_ONE;
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PTR_ONE;
            if (tx_push && !tx_pop)      tx_count_q <= tx_count_q + CNT_ONE;
            else if (!tx_push && tx_pop) tx_count_q <= tx_count_q - CNT_ONE;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_e tx_state_q, tx_state_d;
    logic      sent_inc;
    logic      net_out_req_q;
    logic [15:0] net_out_data_q, sent_num_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state_q <= StIdle;
        else     tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            StIdle:  if (!tx_empty) tx_state_d = StSetup;
            StSetup: tx_state_d = StReqHi;
            StReqHi: if (ack_sync)  tx_state_d = StReqLo;
            StReqLo: if (!ack_sync) tx_state_d = StIdle;
            default: tx_state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_pop   = (tx_state_q == StIdle) && !tx_empty;
        sent_inc = (tx_state_q == StReqHi) && ack_sync;
    end

    // req is a dedicated flop so the asynchronous router never sees decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            net_out_req_q  <= 1'b0;
            net_out_data_q <= '0;
            sent_num_q     <= '0;
        end else begin
            if (tx_pop)                    net_out_data_q <= {2'b00, ^tx_body, tx_body};
            if (tx_state_q == StSetup)     net_out_req_q  <= 1'b1;
            else if (sent_inc)             net_out_req_q  <= 1'b0;
            if (sent_inc)                  sent_num_q     <= sent_num_q + 16'd1;
        end
    end

    assign net_out_req  = net_out_req_q;
    assign net_out_data = net_out_data_q;
    assign sent_num     = sent_num_q;

    // ---------------- RX FIFO ----------------
    logic [8:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [AW:0]   rx_count_q;
    logic          rx_full, rx_push, rx_pop, rx_can_push, parity_err;
    logic [8:0]    rx_head;

    assign rx_full     = (rx_count_q == CNT_FULL);
    assign rx_valid    = (rx_count_q != '0);
    assign rx_pop      = rx_valid && rx_ready;
    assign rx_can_push = !rx_full || rx_pop;
    assign parity_err  = net_in_data[13] ^ (^net_in_data[12:0]);
    assign rx_head     = rx_mem[rx_rd_ptr_q];
    assign rx_err      = rx_valid && rx_head[8];
    assign rx_src      = rx_valid ? rx_head[7:4] : 4'h0;
    assign rx_data     = rx_valid ? rx_head[3:0] : 4'h0;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr_q] <= {parity_err, net_in_data[11:8], net_in_data[3:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PTR_ONE;
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PTR_ONE;
            if (rx_push && !rx_pop)      rx_count_q <= rx_count_q + CNT_ONE;
            else if (!rx_push && rx_pop) rx_count_q <= rx_count_q - CNT_ONE;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_e rx_state_q, rx_state_d;
    logic      ack_clr;
    logic      net_in_ack_q;
    logic [15:0] received_num_q, err_num_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state_q <= StRxIdle;
        else     rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            StRxIdle: if (req_sync && rx_can_push) rx_state_d = StRxAck;
            StRxAck:  if (!req_sync)               rx_state_d = StRxIdle;
            default:  rx_state_d = StRxIdle;
        endcase
    end

    // Holding ack low while the FIFO is full is the backpressure into the router.
    always_comb begin
        rx_push = (rx_state_q == StRxIdle) && req_sync && rx_can_push;
        ack_clr = (rx_state_q == StRxAck) && !req_sync;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            net_in_ack_q   <= 1'b0;
            received_num_q <= '0;
            err_num_q      <= '0;
        end else begin
            if (rx_push)      net_in_ack_q <= 1'b1;
            else if (ack_clr) net_in_ack_q <= 1'b0;
            if (rx_push)               received_num_q <= received_num_q + 16'd1;
            if (rx_push && parity_err) err_num_q      <= err_num_q + 16'd1;
        end
    end

    assign net_in_ack   = net_in_ack_q;
    assign received_num = received_num_q;
    assign err_num      = err_num_q;

endmodule

// File: tb/tb_noc_port_adapter.sv
// Directed self-checking bench for noc_port_adapter: TX/RX handshakes, parity, backpressure,
// TX fill with a self-addressed request, and reset mid-handshake.
module tb_noc_port_adapter;

    localparam int unsigned DEPTH = 4;
    localparam logic [3:0]  ADDR  = 4'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid, tx_ready;
    logic [3:0]  tx_dest, tx_data;
    logic        net_out_req, net_out_ack;
    logic [15:0] net_out_data;
    logic        net_in_req, net_in_ack;
    logic [15:0] net_in_data;
    logic        rx_valid, rx_ready, rx_err;
    logic [3:0]  rx_data, rx_src;
    logic [15:0] sent_num, received_num, err_num;

    int n_cmp = 0;
    int n_err = 0;

    noc_port_adapter #(
        .ADDRESS     (ADDR),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_dest      (tx_dest),
        .tx_data      (tx_data),
        .net_out_req  (net_out_req),
        .net_out_data (net_out_data),
        .net_out_ack  (net_out_ack),
        .net_in_req   (net_in_req),
        .net_in_data  (net_in_data),
        .net_in_ack   (net_in_ack),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_src       (rx_src),
        .rx_err       (rx_err),
        .sent_num     (sent_num),
        .received_num (received_num),
        .err_num      (err_num)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk_pkt(input logic [3:0] src, input logic [3:0] dest,
                                           input logic [3:0] data);
        logic [15:0] p;
        p = {4'b0000, src, dest, data};
        p[13] = ^p[12:0];
        return p;
    endfunction

    task automatic wait_out_req(input logic level, input int budget, input string tag);
        for (int i = 0; i < budget && net_out_req !== level; i++) @(negedge clk);
        check(tag, net_out_req, level);
    endtask

    task automatic wait_in_ack(input logic level, input int budget, input string tag);
        for (int i = 0; i < budget && net_in_ack !== level; i++) @(negedge clk);
        check(tag, net_in_ack, level);
    endtask

    task automatic rx_xfer(input logic [15:0] pkt, input string tag);
        net_in_data = pkt;
        net_in_req  = 1'b1;
        wait_in_ack(1'b1, 10, {tag, "_ack_hi"});
        net_in_req  = 1'b0;
        wait_in_ack(1'b0, 10, {tag, "_ack_lo"});
    endtask

    task automatic rx_pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tx_valid = 1'b0; tx_dest = '0; tx_data = '0;
        net_out_ack = 1'b0; net_in_req = 1'b0; net_in_data = '0; rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_out_req", net_out_req, 1'b0);
        check("rst_out_data", net_out_data, 16'h0000);
        check("rst_in_ack", net_in_ack, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_sent", sent_num, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // TX: dest 5, data A from address 3
        tx_valid = 1'b1; tx_dest = 4'd5; tx_data = 4'hA;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_req_n0", net_out_req, 1'b0);
        @(negedge clk);
        check("tx_req_n1", net_out_req, 1'b0);
        check("tx_data", net_out_data, 16'h035A);
        @(negedge clk);
        check("tx_req_n2", net_out_req, 1'b1);
        net_out_ack = 1'b1;
        wait_out_req(1'b0, 10, "tx_req_fall");
        check("tx_sent1", sent_num, 16'd1);
        net_out_ack = 1'b0;
        repeat (5) @(negedge clk);

        // RX: good packet
        rx_xfer(16'h035A, "rx_good");
        check("rx_valid", rx_valid, 1'b1);
        check("rx_data", rx_data, 4'hA);
        check("rx_src", rx_src, 4'h3);
        check("rx_err0", rx_err, 1'b0);
        check("rx_recv1", received_num, 16'd1);
        check("rx_errn0", err_num, 16'd0);
        rx_pop_one();
        check("rx_empty", rx_valid, 1'b0);

        // RX: parity error
        rx_xfer(16'h0352, "rx_par");
        check("par_err", rx_err, 1'b1);
        check("par_data", rx_data, 4'h2);
        check("par_errn", err_num, 16'd1);
        check("par_recv", received_num, 16'd2);
        rx_pop_one();

        // Backpressure: fill RX FIFO, extra packet must wait for a pop
        for (int i = 0; i < DEPTH; i++) rx_xfer(mk_pkt(4'd7, ADDR, 4'(i)), "bp_fill");
        net_in_data = mk_pkt(4'd7, ADDR, 4'(DEPTH));
        net_in_req  = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_no_ack", net_in_ack, 1'b0);
        rx_pop_one();
        wait_in_ack(1'b1, 3, "bp_release");
        check("bp_head", rx_data, 4'h1);
        check("bp_src", rx_src, 4'h7);
        net_in_req = 1'b0;
        wait_in_ack(1'b0, 10, "bp_ack_lo");
        for (int i = 1; i <= DEPTH; i++) begin
            check("bp_drain_valid", rx_valid, 1'b1);
            check("bp_drain_data", rx_data, 4'(i));
            rx_pop_one();
        end
        check("bp_drained", rx_valid, 1'b0);
        check("bp_recv", received_num, 16'(DEPTH + 3));

        // TX fill with ack stuck low; self-addressed request first
        tx_valid = 1'b1; tx_dest = ADDR; tx_data = 4'hF;
        check("self_ready", tx_ready, 1'b1);
        @(negedge clk);
        for (int i = 0; i <= DEPTH; i++) begin
            tx_dest = 4'd9; tx_data = 4'(i);
            check("fill_ready", tx_ready, 1'b1);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("fill_full", tx_ready, 1'b0);
        check("fill_head", net_out_data, mk_pkt(ADDR, 4'd9, 4'd0));
        check("fill_req", net_out_req, 1'b1);
        net_out_ack = 1'b1;
        wait_out_req(1'b0, 10, "drain_fall");
        net_out_ack = 1'b0;
        wait_out_req(1'b1, 15, "drain_next");
        check("drain_data", net_out_data, mk_pkt(ADDR, 4'd9, 4'd1));
        check("drain_ready", tx_ready, 1'b1);
        check("drain_sent", sent_num, 16'd2);

        // Reset while in REQ_HI
        rst = 1'b1;
        #1;
        check("mid_rst_req", net_out_req, 1'b0);
        check("mid_rst_sent", sent_num, 16'd0);
        check("mid_rst_recv", received_num, 16'd0);
        check("mid_rst_errn", err_num, 16'd0);
        check("mid_rst_ready", tx_ready, 1'b1);
        check("mid_rst_rxv", rx_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_idle", net_out_req, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
